// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and counter width for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_t;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CNT_W = 5;
endpackage

// File: rtl/mdu_compute.sv
// mdu_compute: combinational 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [63:0] result
);
  logic        sgn;
  logic [31:0] ma, mb, db, uq, ur, q, r;
  // Signed divide works on magnitudes and restores signs afterwards; the
  // 0x80000000 / -1 case falls out naturally (quotient wraps to 0x80000000, remainder 0).
  always_comb begin
    sgn = (op == MDU_DIV);
    ma = (sgn && SrcA[31]) ? -SrcA : SrcA;
    mb = (sgn && SrcB[31]) ? -SrcB : SrcB;
    db = (mb == 32'd0) ? 32'd1 : mb;
    uq = ma / db;
    ur = ma % db;
    q = (sgn && (SrcA[31] ^ SrcB[31])) ? -uq : uq;
    r = (sgn && SrcA[31]) ? -ur : ur;
    result = (op == MDU_MULT)  ? {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB} :
             (op == MDU_MULTU) ? {32'd0, SrcA} * {32'd0, SrcB} :
             (SrcB == 32'd0)   ? {SrcA, 32'hFFFF_FFFF} : {r, q};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/DIV unit holding HI/LO; optional cancel port via MDU_CANCEL_EN
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUResult
);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;
  logic [63:0]      res;
  logic             start, kill;
`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif
  assign start = op_valid && !op[2];
  assign busy = (state == RUN);
  assign MDUResult = (op == MDU_MFHI) ? HI : (op == MDU_MFLO) ? LO : 32'd0;
  mdu_compute u_compute (.op(op), .SrcA(SrcA), .SrcB(SrcB), .result(res));
  // Result is captured at start; the counter only models latency before HI/LO commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI      <= '0;
      LO      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !kill) begin
          pend_hi <= res[63:32];
          pend_lo <= res[31:0];
          cnt     <= op[1] ? DIV_N : MULT_N;
          state   <= RUN;
        end else if (op_valid && op == MDU_MTHI) begin
          HI <= SrcA;
        end else if (op_valid && op == MDU_MTLO) begin
          LO <= SrcA;
        end
      end else if (kill) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          HI    <= pend_hi;
          LO    <= pend_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (also covers MDU_CANCEL_EN when defined)
module tb_mult_div_unit;
  import mdu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic        busy, done;
  logic [31:0] HI, LO, MDUResult;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .op_valid(op_valid), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .HI(HI), .LO(LO), .MDUResult(MDUResult)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_hi", HI, e[63:32]);
        chk("sb_lo", LO, e[31:0]);
      end
    end
  end
  // caller is at a negedge; issues op for one cycle and returns one negedge later
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; SrcA = a; SrcB = b;
    @(negedge clk);
    op_valid = 1'b0; op = MDU_MULT; SrcA = '0; SrcB = '0;
  endtask
  // start an op, count busy cycles, end at the negedge of the done cycle
  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int n, input logic [31:0] eh, input logic [31:0] el);
    int c;
    exp_q.push_back({eh, el});
    issue(o, a, b);
    c = 0;
    while (busy && c < 40) begin
      c++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 32'(c), 32'(n));
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(MDU_MTHI, 32'hAAAA_0001, 32'd0);
    issue(MDU_MTLO, 32'hBBBB_0002, 32'd0);
    chk("mthi", HI, 32'hAAAA_0001);
    chk("mtlo", LO, 32'hBBBB_0002);
    issue(MDU_MULT, 32'd9, 32'd9);
    @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_hi_after", HI, 32'd0);
    run("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'd2, 32'hFFFF_FFFA);
    run("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_negb", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run("divu_zero", MDU_DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
    run("div_zero", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run("divu_big", MDU_DIVU, 32'hFFFF_FFFF, 32'd10, 10, 32'd5, 32'h1999_9999);
    @(negedge clk);
    issue(MDU_MTLO, 32'h1234, 32'd0);
    op = MDU_MFLO;
    #1;
    chk("mflo", MDUResult, 32'h1234);
    op = MDU_MFHI;
    #1;
    chk("mfhi", MDUResult, 32'd5);
    op = MDU_MTHI;
    #1;
    chk("mdures_other", MDUResult, 32'd0);
    @(negedge clk);
    exp_q.push_back({32'd0, 32'd42});
    issue(MDU_MULT, 32'd6, 32'd7);
    issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_busy_hi", HI, 32'd5);
    op = MDU_MFHI;
    #1;
    chk("mfhi_busy", MDUResult, 32'd5);
    op = MDU_MULT;
    begin
      int c = 0;
      while (!done && c < 20) begin
        c++;
        @(negedge clk);
      end
      chk("mthi_busy_done", 32'(done), 32'd1);
    end
    chk("mthi_busy_final", HI, 32'd0);
    @(negedge clk);
    run("b2b_divu", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run("b2b_mult", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd1);
    @(negedge clk);
`ifdef MDU_CANCEL_EN
    issue(MDU_DIV, 32'd50, 32'd3);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_done", 32'(done), 32'd0);
    chk("cancel_hi", HI, 32'd0);
    chk("cancel_lo", LO, 32'd1);
    cancel = 1'b1;
    issue(MDU_MULT, 32'd3, 32'd3);
    cancel = 1'b0;
    chk("cancel_start_busy", 32'(busy), 32'd0);
    repeat (14) @(negedge clk);
    chk("cancel_lo_after", LO, 32'd1);
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Takes the same operands (SrcA/SrcB from the ID/EX register) and holds the HI/LO architectural registers.
- Executes MULT/MULTU/DIV/DIVU over several cycles, writes HI/LO via MTHI/MTLO, and returns HI/LO on MFHI/MFLO.
- Asserts busy so the hazard unit can stall any following MDU instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (range 1..31).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..31).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  qualifies op for the current cycle.
- op  input  3  MDU operation code (encoding in package).
- SrcA  input  32  operand A (rs); dividend for DIV/DIVU.
- SrcB  input  32  operand B (rt); divisor for DIV/DIVU.
- busy  output  1  multi-cycle operation in flight.
- done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MDUResult  output  32  combinational: HI when op==MFHI, LO when op==MFLO, else 0.

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, done=0, counter=0, FSM=IDLE. Asserting reset mid-operation discards the result.
- FSM states: IDLE, RUN.
- IDLE -> RUN on op_valid with MULT, MULTU, DIV or DIVU at edge T.
  - At that edge: latch the full 64-bit result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- RUN: counter decrements every edge. busy=1 in cycles T+1..T+N.
- RUN -> IDLE on the edge where counter goes 1->0.
  - At that edge: HI<=pending_hi, LO<=pending_lo, done<=1 for exactly one cycle (cycle T+N+1).
  - New HI/LO are visible from cycle T+N+1.
- MULT: signed 32x32 -> 64; HI=product[63:32], LO=product[31:0].
- MULTU: same as MULT, unsigned.
- DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV/DIVU): LO=32'hFFFF_FFFF, HI=SrcA. Normal latency applies.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- MTHI/MTLO with op_valid in IDLE: HI (or LO) <= SrcA at the edge. No busy.
- Any op_valid while busy (MULT/DIV/MTHI/MTLO): ignored and state unchanged. The hazard unit guarantees this does not happen.
- MDUResult is purely combinational from op and the current HI/LO. op_valid is not required.
- MFHI/MFLO while busy return the old HI/LO (the hazard unit stalls these).
- Back-to-back: a new start is accepted in cycle T+N+1, the same cycle done is high.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel high at an edge while RUN: returns to IDLE, busy=0, done stays 0, HI/LO unchanged.
  - cancel in IDLE has no effect.
  - cancel with a simultaneous start: cancel wins; the start is dropped.
  - Used for exception flush.
- Undefined: no cancel port; an operation always completes.

Decomposition:
- Package mdu_pkg holds:
  - op codes: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MFHI=6, MDU_MFLO=7;
  - state typedef {IDLE, RUN};
  - counter width constant 5.
- One sub-module, mdu_compute: combinational 64-bit result from op/SrcA/SrcB, including the div-by-zero and overflow rules.
- Top level keeps the FSM, counter and HI/LO.

Test Plan:
- Reset mid-MULT: reset at cycle 3 of 5 -> HI=LO=0, busy=0 immediately, done never pulses.
- MULT SrcA=32'hFFFF_FFFE (-2), SrcB=3 -> busy for 5 cycles; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA at T+6 with done=1.
- MULTU with the same operands -> HI=2, LO=32'hFFFF_FFFA.
- DIV -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF after 10 busy cycles.
- DIVU 7/0 -> LO=32'hFFFF_FFFF, HI=7.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0.
- MTLO 32'h1234 in IDLE, then op=MFLO -> MDUResult=32'h1234 the next cycle.
- MTHI issued while busy -> HI unchanged.
- Back-to-back DIVU then MULT, with the start in the done cycle -> second result lands 5 cycles after acceptance.
- With MDU_CANCEL_EN: cancel pulse while busy -> busy=0 next cycle, done=0, HI/LO keep their prior values.
